iob_nco_sweep_ctrl: RTL
=======================

Name: iob_nco_sweep_ctrl

Overview:
- Autonomous frequency-sweep sequencer for iob_nco: an IOb-native write-only master that drives the NCO CSR port.
- Programs soft reset, period and enable, then steps the 64-bit period (32.32 fixed point) by a signed increment after a programmable dwell per point.
- Sits between a host/config block and the NCO CSR slave, so software needs no per-step CSR writes.

Parameters:
- DATA_W, 32, CSR bus data width (fixed 32).
- ADDR_W, 4, CSR byte-address width.
- DWELL_W, 32, dwell counter width.
- NSTEPS_W, 16, step counter width.
- SOFT_RESET_ADDR, 0, byte address of NCO SOFT_RESET (1-byte reg).
- ENABLE_ADDR, 1, byte address of NCO ENABLE (1-byte reg).
- PERIOD_INT_ADDR, 4, byte address of PERIOD_INT (word).
- PERIOD_FRAC_ADDR, 8, byte address of PERIOD_FRAC (word).

Ports:
- clk_i  in  1  system clock
- arst_n_i  in  1  asynchronous reset, active low
- start_i  in  1  start-sweep pulse; sampled only in IDLE
- abort_i  in  1  stop sweep, disable NCO
- period_start_i  in  64  initial period {int[63:32], frac[31:0]}
- period_step_i  in  64  signed two's-complement increment per point
- nsteps_i  in  NSTEPS_W  increments after the first point (points = nsteps+1)
- dwell_i  in  DWELL_W  cycles each point is held after its final write accepted
- iob_valid_o  out  1  request valid
- iob_addr_o  out  ADDR_W  byte address
- iob_wdata_o  out  DATA_W  write data
- iob_wstrb_o  out  DATA_W/8  byte strobes
- iob_ready_i  in  1  slave accepts request
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse on sweep end (normal or abort)
- step_idx_o  out  NSTEPS_W  index of current point
- cur_period_o  out  64  period currently programmed or being programmed

Behaviour:
- Reset values: iob_valid_o=0, iob_addr_o=0, iob_wdata_o=0, iob_wstrb_o=0, busy_o=0, done_o=0, step_idx_o=0, cur_period_o=0. Reset is asynchronous and may force valid low mid-transaction.
- Start capture: start_i in IDLE latches all config inputs; inputs are ignored afterward. start_i outside IDLE is ignored.
- Handshake: each write holds valid/addr/wdata/wstrb stable until a posedge with iob_ready_i=1. Next request is presented the following cycle (no back-to-back valid). Zero-wait slave gives 2 cycles per write.
- Byte registers: wstrb=1<<addr[1:0], value placed at wdata[8*addr[1:0]+:8], other bytes 0.
- Word registers: wstrb=all ones.
- States:
  - IDLE -(start)-> SRST1: write SOFT_RESET=1.
  - SRST1 -> SRST0: write SOFT_RESET=0.
  - SRST0 -> WINT: write PERIOD_INT=cur[63:32].
  - WINT -> WFRAC: write PERIOD_FRAC=cur[31:0].
  - WFRAC -> WEN if first point (write ENABLE=1), else DWELL.
  - WEN -> DWELL.
  - DWELL: count dwell cycles (dwell=0 leaves after 1 cycle). At expiry: if step_idx==nsteps go WDIS, else cur+=step (mod 2^64), step_idx++, go WINT.
  - WDIS: write ENABLE=0.
  - WDIS -> DONE: done_o=1 for one cycle, then IDLE.
- Abort: if a request is pending, it completes first. Then WDIS, DONE. Abort in IDLE is ignored. Abort and start in the same IDLE cycle: start wins, abort ignored.
- Wrap: period arithmetic wraps modulo 2^64, with no saturation. Step counter never wraps: it terminates at nsteps.
- cur_period_o/step_idx_o hold their final values after DONE until the next start.

Test Plan:
- Start with period_start=0x00000012_80000000, step=0, nsteps=0, dwell=5, always-ready slave -> writes in order (0,0x01,strb 0001), (0,0x00), (4,0x12), (8,0x80000000), (1,0x0100,strb 0010), 5-cycle dwell, (1,0x0000); done_o single pulse; busy_o low afterward.
- Sweep start=0x10_00000000, step=0x0_80000000, nsteps=3, dwell=10 -> INT/FRAC pairs 0x10/0, 0x10/0x80000000, 0x11/0, 0x11/0x80000000; ENABLE=1 written exactly once; step_idx_o ends 3.
- Negative step=0xFFFFFFFF_00000000 from start=0x1_00000000, nsteps=2 -> INT writes 0x1, 0x0, 0xFFFFFFFF (wrap), FRAC 0 each.
- Slave with random 0-4 cycle ready stalls -> addr/wdata/wstrb stable while valid=1; write sequence identical to the zero-wait case.
- abort_i during a stalled WINT write -> that write completes, next write is ENABLE=0, done_o pulses, no further period writes; a start_i pulse mid-sweep has no effect.
- arst_n_i asserted during DWELL -> all outputs 0 immediately; a new start after release restarts from SRST1.

Source files
------------

// File: rtl/iob_nco_sweep_ctrl.sv
// iob_nco_sweep_ctrl: autonomous frequency-sweep sequencer for iob_nco.
// Acts as a write-only IOb master on the NCO CSR port. It soft-resets the
// NCO, programs the 32.32 period, enables it, then repeatedly adds a signed
// increment to the period after a programmable dwell per point.
module iob_nco_sweep_ctrl #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 4,
    parameter int DWELL_W          = 32,
    parameter int NSTEPS_W         = 16,
    parameter int SOFT_RESET_ADDR  = 0,
    parameter int ENABLE_ADDR      = 1,
    parameter int PERIOD_INT_ADDR  = 4,
    parameter int PERIOD_FRAC_ADDR = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [63:0]           period_start_i,
    input  logic [63:0]           period_step_i,
    input  logic [NSTEPS_W-1:0]   nsteps_i,
    input  logic [DWELL_W-1:0]    dwell_i,
    output logic                  iob_valid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [NSTEPS_W-1:0]   step_idx_o,
    output logic [63:0]           cur_period_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] A_SRST = ADDR_W'(SOFT_RESET_ADDR);
    localparam logic [ADDR_W-1:0] A_EN   = ADDR_W'(ENABLE_ADDR);
    localparam logic [ADDR_W-1:0] A_PINT = ADDR_W'(PERIOD_INT_ADDR);
    localparam logic [ADDR_W-1:0] A_PFRC = ADDR_W'(PERIOD_FRAC_ADDR);

    typedef enum logic [3:0] {
        S_IDLE, S_SRST1, S_SRST0, S_WINT, S_WFRAC, S_WEN, S_DWELL, S_WDIS, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [NSTEPS_W-1:0]   step_idx_q, step_idx_d;
    logic [63:0]           cur_q, cur_d;
    logic [63:0]           step_q, step_d;
    logic [NSTEPS_W-1:0]   nsteps_q, nsteps_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic [DWELL_W-1:0]    cnt_q, cnt_d;
    logic                  abort_q, abort_d;

    // per-state request description, consumed by the shared handshake logic
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_val;
    logic                  req_byte;
    state_t                wr_next;
    logic                  abort_eff;

    // next-state, request generation and datapath updates
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        step_idx_d = step_idx_q;
        cur_d      = cur_q;
        step_d     = step_q;
        nsteps_d   = nsteps_q;
        dwell_d    = dwell_q;
        cnt_d      = cnt_q;
        // an abort seen during a write is remembered until that write retires
        abort_d    = abort_q | (abort_i && state_q != S_IDLE &&
                                state_q != S_WDIS && state_q != S_DONE);
        abort_eff  = abort_q | abort_i;
        req_addr   = '0;
        req_val    = '0;
        req_byte   = 1'b0;
        wr_next    = state_q;

        case (state_q)
            S_SRST1: begin req_addr = A_SRST; req_val = DATA_W'(1); req_byte = 1'b1; wr_next = S_SRST0; end
            S_SRST0: begin req_addr = A_SRST; req_val = '0;         req_byte = 1'b1; wr_next = S_WINT;  end
            S_WINT:  begin req_addr = A_PINT; req_val = cur_q[63:32];                wr_next = S_WFRAC; end
            S_WFRAC: begin
                req_addr = A_PFRC;
                req_val  = cur_q[31:0];
                // only the first point needs the NCO enabled
                wr_next  = (step_idx_q == '0) ? S_WEN : S_DWELL;
            end
            S_WEN:   begin req_addr = A_EN;   req_val = DATA_W'(1); req_byte = 1'b1; wr_next = S_DWELL; end
            S_WDIS:  begin req_addr = A_EN;   req_val = '0;         req_byte = 1'b1; wr_next = S_DONE;  end
            default: ;
        endcase

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start_i) begin
                    cur_d      = period_start_i;
                    step_d     = period_step_i;
                    nsteps_d   = nsteps_i;
                    dwell_d    = dwell_i;
                    step_idx_d = '0;
                    state_d    = S_SRST1;
                end
            end
            S_DWELL: begin
                if (abort_eff) begin
                    state_d = S_WDIS;
                end else if (cnt_q <= DWELL_W'(1)) begin
                    if (step_idx_q == nsteps_q) begin
                        state_d = S_WDIS;
                    end else begin
                        cur_d      = cur_q + step_q;
                        step_idx_d = step_idx_q + NSTEPS_W'(1);
                        state_d    = S_WINT;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                // write states: one idle cycle, then hold the request until accepted
                if (!valid_q) begin
                    if (abort_eff && state_q != S_WDIS) begin
                        state_d = S_WDIS;
                    end else begin
                        valid_d = 1'b1;
                        addr_d  = req_addr;
                        if (req_byte) begin
                            wstrb_d = STRB_W'(1) << req_addr[1:0];
                            wdata_d = DATA_W'(req_val[7:0]) << {req_addr[1:0], 3'b000};
                        end else begin
                            wstrb_d = '1;
                            wdata_d = req_val;
                        end
                    end
                end else if (iob_ready_i) begin
                    valid_d = 1'b0;
                    state_d = (abort_eff && state_q != S_WDIS) ? S_WDIS : wr_next;
                end
            end
        endcase

        // dwell counter is reloaded on every entry to DWELL
        if (state_d == S_DWELL && state_q != S_DWELL) cnt_d = dwell_q;
    end

    // state and datapath registers
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            step_idx_q <= '0;
            cur_q      <= '0;
            step_q     <= '0;
            nsteps_q   <= '0;
            dwell_q    <= '0;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            step_idx_q <= step_idx_d;
            cur_q      <= cur_d;
            step_q     <= step_d;
            nsteps_q   <= nsteps_d;
            dwell_q    <= dwell_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
        end
    end

    assign iob_valid_o  = valid_q;
    assign iob_addr_o   = addr_q;
    assign iob_wdata_o  = wdata_q;
    assign iob_wstrb_o  = wstrb_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign step_idx_o   = step_idx_q;
    assign cur_period_o = cur_q;

endmodule
